// File: rtl/mm_pkg.sv
// Shared types and width helpers for the matrix-multiply index path.
// The operand-fetch and MAC blocks size their index buses with the same
// helpers, so all of them agree on widths for a given N.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for a loop of n values. Returns at least 1 so that n=1
  // never produces a zero-width bus.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width that holds a beat count from 0 to n^3 inclusive.
  function automatic int beat_w(input int n);
    return $clog2(n * n * n + 1);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter with a synchronous clear and a terminal-count flag.
// Wrap is an explicit compare against MOD-1, so MOD need not be a power of 2.
module mod_counter
  import mm_pkg::*;
#(
  parameter int MOD = 2,
  parameter int W   = idx_w(MOD)
) (
  input  logic         clk,
  input  logic         mr,
  input  logic         ce,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign tc = (count == LAST);

  // Count on ce, wrap at MOD-1; clear wins over counting.
  always_ff @(posedge clk or negedge mr) begin
    if (!mr)      count <= '0;
    else if (clr) count <= '0;
    else if (ce)  count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/mm_index_sequencer.sv
// Loop-index sequencer for an N x N matrix multiply, k innermost.
// It walks (i,j,k) through N^3 beats with a start/busy/done handshake,
// a stall enable, and an abort. All outputs come from registers or from
// a decode of registered state.
module mm_index_sequencer
  import mm_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N),
  parameter int CW = beat_w(N)
) (
  input  logic          clk,
  input  logic          mr,
  input  logic          start,
  input  logic          ce,
  input  logic          abort,
  output logic          busy,
  output logic          valid,
  output logic [IW-1:0] idx_i,
  output logic [IW-1:0] idx_j,
  output logic [IW-1:0] idx_k,
  output logic          k_first,
  output logic          k_last,
  output logic          done,
  output logic [CW-1:0] beat_count
);

  state_t state;
  logic   tc_i, tc_j, tc_k;
  logic   go, adv, clr, last_beat;

  // A beat is accepted only in RUN, with ce high and no abort.
  assign go        = (state == IDLE) && start && !abort;
  assign adv       = (state == RUN) && ce && !abort;
  assign clr       = go || ((state == RUN) && abort);
  assign last_beat = adv && tc_k && tc_j && tc_i;

  mod_counter #(.MOD(N), .W(IW)) u_k (
    .clk(clk), .mr(mr), .ce(adv), .clr(clr), .count(idx_k), .tc(tc_k)
  );
  mod_counter #(.MOD(N), .W(IW)) u_j (
    .clk(clk), .mr(mr), .ce(adv && tc_k), .clr(clr), .count(idx_j), .tc(tc_j)
  );
  mod_counter #(.MOD(N), .W(IW)) u_i (
    .clk(clk), .mr(mr), .ce(adv && tc_k && tc_j), .clr(clr), .count(idx_i), .tc(tc_i)
  );

  // Accumulator-control flags are decoded from the registered valid and idx_k.
  assign k_first = valid && (idx_k == '0);
  assign k_last  = valid && (idx_k == IW'(N - 1));

  // Sequence FSM with registered handshake outputs and the beat counter.
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      state      <= IDLE;
      busy       <= 1'b0;
      valid      <= 1'b0;
      done       <= 1'b0;
      beat_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state      <= RUN;
            busy       <= 1'b1;
            valid      <= 1'b1;
            beat_count <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            // The partial beat count is kept so the controller can read it.
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
          end else if (ce) begin
            beat_count <= beat_count + 1'b1;
            if (last_beat) begin
              state <= DONE;
              valid <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_index_sequencer.sv
// Directed bench for mm_index_sequencer at N=2 and N=3.
// The expected index tuples are queued when a start is driven. They are
// consumed as the DUT presents beats.
module tb_mm_index_sequencer;

  typedef struct {int i; int j; int k;} tup_t;

  logic       clk = 1'b0;
  logic       mr;
  logic       start2, ce2, ab2;
  logic       busy2, v2, kf2, kl2, d2;
  logic [0:0] i2, j2, k2;
  logic [3:0] bc2;
  logic       start3, ce3, ab3;
  logic       busy3, v3, kf3, kl3, d3;
  logic [1:0] i3, j3, k3;
  logic [4:0] bc3;

  tup_t q2[$];
  tup_t q3[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt = 0;
  int   sp;
  int   done2_cnt = 0, done2_at = -1;
  int   done3_cnt = 0, done3_at = -1;

  always #5 clk = ~clk;

  mm_index_sequencer #(.N(2)) dut2 (
    .clk(clk), .mr(mr), .start(start2), .ce(ce2), .abort(ab2),
    .busy(busy2), .valid(v2), .idx_i(i2), .idx_j(j2), .idx_k(k2),
    .k_first(kf2), .k_last(kl2), .done(d2), .beat_count(bc2)
  );

  mm_index_sequencer #(.N(3)) dut3 (
    .clk(clk), .mr(mr), .start(start3), .ce(ce3), .abort(ab3),
    .busy(busy3), .valid(v3), .idx_i(i3), .idx_j(j3), .idx_k(k3),
    .k_first(kf3), .k_last(kl3), .done(d3), .beat_count(bc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push2();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++) q2.push_back('{i, j, k});
  endtask

  task automatic push3();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 3; k++) q3.push_back('{i, j, k});
  endtask

  // Sample on the falling edge. Then advance one rising edge and settle 1 time unit.
  task automatic cyc();
    @(negedge clk);
    if (v2) begin
      chk("n2_beat_expected", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        chk("n2_i", i2, q2[0].i);
        chk("n2_j", j2, q2[0].j);
        chk("n2_k", k2, q2[0].k);
        chk("n2_kfirst", kf2, q2[0].k == 0);
        chk("n2_klast", kl2, q2[0].k == 1);
        if (ce2 && !ab2) void'(q2.pop_front());
      end
    end
    if (d2) begin
      done2_cnt++;
      done2_at = cnt;
      chk("n2_done_early", q2.size(), 0);
    end
    if (v3) begin
      chk("n3_beat_expected", q3.size() > 0, 1);
      chk("n3_range", (i3 < 3) && (j3 < 3) && (k3 < 3), 1);
      if (q3.size() > 0) begin
        chk("n3_i", i3, q3[0].i);
        chk("n3_j", j3, q3[0].j);
        chk("n3_k", k3, q3[0].k);
        chk("n3_kfirst", kf3, q3[0].k == 0);
        chk("n3_klast", kl3, q3[0].k == 2);
        if (ce3 && !ab3) void'(q3.pop_front());
      end
    end
    if (d3) begin
      done3_cnt++;
      done3_at = cnt;
      chk("n3_done_early", q3.size(), 0);
    end
    @(posedge clk);
    #1;
    cnt++;
  endtask

  initial begin
    mr = 1'b0;
    start2 = 0; ce2 = 0; ab2 = 0;
    start3 = 0; ce3 = 0; ab3 = 0;
    #3;
    chk("rst_busy", busy2, 0);
    chk("rst_valid", v2, 0);
    chk("rst_done", d2, 0);
    chk("rst_idx", {i2, j2, k2}, 0);
    chk("rst_beats", bc2, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_beats3", bc3, 0);
    #10 mr = 1'b1;
    cyc(); cyc();

    // N=2, ce held high: 8 beats, then done 8 edges after the start edge
    ce2 = 1; push2(); start2 = 1; cyc(); start2 = 0; sp = cnt;
    chk("t1_valid_after_start", v2, 1);
    repeat (12) cyc();
    chk("t1_done_cnt", done2_cnt, 1);
    chk("t1_done_at", done2_at - sp, 8);
    chk("t1_beats", bc2, 8);
    chk("t1_drained", q2.size(), 0);
    chk("t1_idle", busy2, 0);

    // N=2, ce toggling: each tuple held two cycles, done after 8th accepted beat
    push2(); start2 = 1; cyc(); start2 = 0; sp = cnt;
    for (int t = 0; t < 20; t++) begin
      ce2 = (t % 2 == 0);
      cyc();
    end
    chk("t2_done_cnt", done2_cnt, 2);
    chk("t2_done_at", done2_at - sp, 15);
    chk("t2_beats", bc2, 8);
    chk("t2_drained", q2.size(), 0);

    // N=3: 27 beats, carry after k=2, done 27 edges after start
    ce2 = 1; ce3 = 1; push3(); start3 = 1; cyc(); start3 = 0; sp = cnt;
    repeat (32) cyc();
    chk("t3_done_cnt", done3_cnt, 1);
    chk("t3_done_at", done3_at - sp, 27);
    chk("t3_beats", bc3, 27);
    chk("t3_drained", q3.size(), 0);
    chk("t3_idle", busy3, 0);

    // N=2 abort after 5 accepted beats
    push2(); start2 = 1; cyc(); start2 = 0;
    repeat (5) cyc();
    ab2 = 1; cyc(); ab2 = 0;
    q2.delete();
    chk("t4_busy", busy2, 0);
    chk("t4_valid", v2, 0);
    chk("t4_idx", {i2, j2, k2}, 0);
    chk("t4_beats", bc2, 5);
    cyc();
    chk("t4_no_done", done2_cnt, 2);
    push2(); start2 = 1; cyc(); start2 = 0;
    chk("t4_restart_idx", {v2, i2, j2, k2}, 4'b1000);
    repeat (12) cyc();
    chk("t4_restart_done", done2_cnt, 3);
    chk("t4_restart_beats", bc2, 8);

    // start during RUN and during DONE is ignored
    push2(); start2 = 1; cyc(); start2 = 0; sp = cnt;
    repeat (3) cyc();
    start2 = 1; cyc(); start2 = 0;
    repeat (4) cyc();
    chk("t5_in_done", d2, 1);
    start2 = 1; cyc(); start2 = 0;
    chk("t5_idle_after_done", busy2, 0);
    repeat (4) cyc();
    chk("t5_done_cnt", done2_cnt, 4);
    chk("t5_done_at", done2_at - sp, 8);
    chk("t5_beats", bc2, 8);
    chk("t5_drained", q2.size(), 0);
    start2 = 1; ab2 = 1; cyc(); start2 = 0; ab2 = 0;
    chk("t5_start_abort_busy", busy2, 0);
    chk("t5_start_abort_valid", v2, 0);
    cyc();
    chk("t5_start_abort_beats", bc2, 8);

    // asynchronous reset mid-run after 3 beats
    push2(); start2 = 1; cyc(); start2 = 0;
    repeat (3) cyc();
    chk("t6_running", {v2, bc2}, {1'b1, 4'd3});
    #2 mr = 1'b0;
    #1;
    chk("t6_busy", busy2, 0);
    chk("t6_valid", v2, 0);
    chk("t6_done", d2, 0);
    chk("t6_idx", {i2, j2, k2}, 0);
    chk("t6_beats", bc2, 0);
    q2.delete();
    #2 mr = 1'b1;
    repeat (3) cyc();
    chk("t6_stays_idle", {busy2, v2}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mm_index_sequencer.md
Name: mm_index_sequencer

Overview:
- Parametrised successor to the 3-bit step counter in the matrix-multiplier control path. Generates the (i, j, k) loop indices for an N x N matrix multiply C[i][j] += A[i][k]*B[k][j], k innermost.
- Adds a start/busy/done handshake, a stall enable, a synchronous abort, accumulator-control flags and a beat count.
- Sits between the top-level controller and the operand-fetch/MAC datapath.

Parameters:
- N, 2, matrix dimension; legal N >= 2, not required to be a power of 2.
- IW, $clog2(N), index width; derived.
- CW, $clog2(N*N*N+1), beat-count width; derived.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- mr  in  1  master reset; asynchronous, active-low.
- start  in  1  begin a sequence; honoured only in IDLE.
- ce  in  1  advance enable; 0 = stall, hold indices.
- abort  in  1  synchronous abandon of the current sequence.
- busy  out  1  high whenever state != IDLE.
- valid  out  1  indices valid; high in RUN.
- idx_i  out  IW  row index of A/C.
- idx_j  out  IW  column index of B/C.
- idx_k  out  IW  inner-product index.
- k_first  out  1  valid && idx_k==0; accumulator clear.
- k_last  out  1  valid && idx_k==N-1; C write-back.
- done  out  1  one-cycle pulse after the final beat.
- beat_count  out  CW  number of accepted beats in the current or last sequence.

Behaviour:
- Reset (mr=0, asynchronous): state IDLE; idx_i, idx_j, idx_k = 0; beat_count = 0; busy, valid, done = 0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 && abort=0 -> RUN. Indices and beat_count are cleared to 0 on that same edge. valid rises one cycle after start is sampled.
  - RUN: a beat is accepted on each edge with ce=1.
    - idx_k increments. At N-1 it wraps to 0 and carries into idx_j; idx_j wraps at N-1 and carries into idx_i.
    - beat_count increments on each accepted beat.
    - ce=0: all state holds; valid stays 1.
  - RUN, final beat (i=j=k=N-1 accepted with ce=1) -> DONE. Indices wrap to 0; beat_count = N^3.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE unconditionally.
- abort=1 in RUN -> IDLE on the next edge.
  - Indices clear to 0; beat_count holds its partial value; no done pulse.
  - abort takes priority over ce and over the final-beat transition.
- abort in IDLE or DONE has no effect beyond blocking a same-cycle start.
- start while RUN or DONE is ignored; it is not queued.
- Indices never reach N. Wrap is an explicit compare against N-1, not a power-of-2 overflow.
- With ce held 1: N^3 valid cycles, then done in cycle N^3+1 after the start edge.
- beat_count holds its final value until the next accepted start.
- All outputs are registered or decoded from registered state only. There are no combinational paths from start, ce or abort to any output.

Decomposition:
- Package mm_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the index-width and beat-width helper constants, shared with the operand-fetch and MAC blocks.
- Sub-module mod_counter:
  - Parameter MOD; inputs clk, mr, ce, clr; outputs count and tc (count==MOD-1).
  - Three instances are chained (k -> j -> i), each ce'd by the lower counter's tc && ce.

Test Plan:
- N=2, ce=1, start pulse: 8 beats in order (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0) ... (1,1,1). k_first on even beats, k_last on odd beats. done in cycle 9 after the start edge; beat_count=8.
- N=2, ce toggling 1,0,1,0: each index tuple held for 2 cycles; still 8 accepted beats; done after the 8th accepted beat only.
- N=3: 27 beats; idx_* never equals 3; the k->j carry occurs after k=2; done after 27 beats; beat_count=27.
- N=2, abort at beat 5: busy drops the next cycle, indices return to 0, no done pulse, beat_count=5. A following start restarts from (0,0,0).
- N=2, start asserted during RUN and during DONE: ignored, sequence length unchanged. Start and abort together in IDLE: stays IDLE.
- mr deasserted-then-asserted low mid-run at beat 3: all outputs 0 immediately, without waiting for clk. After release, IDLE until start.
